// File: rtl/i2s_mix_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : i2s_mix_scheduler
// Brief   : Once per I2S frame, polls each enabled voice over a req/valid
//           handshake, sums the signed samples with saturation and commits
//           one held mix sample for the transmitter's next left-channel latch.
// Rev     : 1.0 - initial release
// ============================================================================
module i2s_mix_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int TIMEOUT    = 64,
  localparam int SEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ws_in,
  input  logic [NUM_VOICES-1:0] voice_enable,
  output logic                  voice_req,
  output logic [SEL_W-1:0]      voice_sel,
  input  logic                  voice_valid,
  input  logic [SAMPLE_W-1:0]   voice_sample,
  output logic [SAMPLE_W-1:0]   mix_sample,
  output logic                  frame_done,
  output logic                  clip,
  output logic                  timeout,
  output logic                  overrun,
  input  logic                  clear_flags
);

  // Accumulator has enough headroom for NUM_VOICES full-scale samples.
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_VOICES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SCAN   = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] SAT    = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  logic [2:0]              state;
  logic [SEL_W-1:0]        idx;
  logic [TMR_W-1:0]        timer;
  logic signed [ACC_W-1:0] acc;
  logic                    ws_s1, ws_s2, ws_s3;
  logic                    start;

  logic                    last;
  logic signed [ACC_W-1:0] sample_ext;
  logic [ACC_W-SAMPLE_W:0] acc_hi;
  logic                    acc_ovf;
  logic [SAMPLE_W-1:0]     clamped;

  assign last       = (idx == LAST_IDX);
  assign sample_ext = ACC_W'($signed(voice_sample));

  // The mix fits when all bits from the sample MSB upward agree (pure sign
  // extension); otherwise clamp toward the accumulator's sign.
  assign acc_hi  = acc[ACC_W-1:SAMPLE_W-1];
  assign acc_ovf = ~((&acc_hi) | ~(|acc_hi));
  assign clamped = !acc_ovf ? acc[SAMPLE_W-1:0] :
                   acc[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} :
                                  {1'b0, {(SAMPLE_W-1){1'b1}}};

  // Synchronize word_select and register a one-cycle pulse on its falling
  // edge; the FFs reset high so leaving reset never looks like a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_s1 <= 1'b1;
      ws_s2 <= 1'b1;
      ws_s3 <= 1'b1;
      start <= 1'b0;
    end else begin
      ws_s1 <= ws_in;
      ws_s2 <= ws_s1;
      ws_s3 <= ws_s2;
      start <= ws_s3 & ~ws_s2;
    end
  end

  // Round sequencer: scan voices, collect samples, saturate and commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      timer      <= '0;
      acc        <= '0;
      voice_req  <= 1'b0;
      voice_sel  <= '0;
      mix_sample <= '0;
      frame_done <= 1'b0;
      clip       <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Clear first so a same-cycle set event below takes priority.
      if (clear_flags) begin
        clip    <= 1'b0;
        timeout <= 1'b0;
        overrun <= 1'b0;
      end
      // A frame start mid-round is flagged and otherwise ignored.
      if (start && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            acc   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (voice_enable[idx]) begin
            voice_req <= 1'b1;
            voice_sel <= idx;
            timer     <= '0;
            state     <= WAIT;
          end else if (last) begin
            state <= SAT;
          end else begin
            idx <= idx + SEL_W'(1);
          end
        end
        WAIT: begin
          if ((voice_valid && voice_req) || timer == TMR_LAST) begin
            if (voice_valid && voice_req) begin
              acc <= acc + sample_ext;
            end else begin
              timeout <= 1'b1;
            end
            voice_req <= 1'b0;
            if (last) begin
              state <= SAT;
            end else begin
              idx   <= idx + SEL_W'(1);
              state <= SCAN;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SAT: begin
          // Results become visible together in the COMMIT cycle.
          mix_sample <= clamped;
          frame_done <= 1'b1;
          if (acc_ovf) begin
            clip <= 1'b1;
          end
          state <= COMMIT;
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_mix_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_i2s_mix_scheduler
// Brief   : Directed plus randomized rounds against a behavioural mix model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_i2s_mix_scheduler;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ws;
  logic [3:0]  en;
  logic        req;
  logic [1:0]  sel;
  logic        valid;
  logic [15:0] vsample;
  logic [15:0] mix;
  logic        fd, clip, tmo_f, ovr;
  logic        clear;

  int          total = 0;
  int          bad   = 0;

  // Per-voice behaviour: lat = WAIT cycle (1-based) of the answer, 0 = never.
  int          lat [4];
  logic [15:0] samp[4];
  logic [3:0]  seen;
  bit          m_clip, m_to, m_ov;
  logic [15:0] prev_mix;
  bit          prev_ok = 1'b0;

  i2s_mix_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .ws_in        (ws),
    .voice_enable (en),
    .voice_req    (req),
    .voice_sel    (sel),
    .voice_valid  (valid),
    .voice_sample (vsample),
    .mix_sample   (mix),
    .frame_done   (fd),
    .clip         (clip),
    .timeout      (tmo_f),
    .overrun      (ovr),
    .clear_flags  (clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Voice responder: answers in the programmed WAIT cycle, junk otherwise.
  initial begin
    int c;
    c = 0;
    valid = 1'b0;
    vsample = '0;
    forever begin
      @(negedge clk);
      if (req) begin
        c++;
        if (lat[sel] != 0 && c == lat[sel]) begin
          valid = 1'b1;
          vsample = samp[sel];
        end else begin
          valid = 1'b0;
          vsample = 16'($urandom);
        end
      end else begin
        c = 0;
        valid = 1'($urandom);
        vsample = 16'($urandom);
      end
    end
  end

  // Monitor: record polled voices; the mix may only move with frame_done.
  always @(negedge clk) begin
    if (rst && req) seen[sel] = 1'b1;
    if (rst && prev_ok && mix !== prev_mix) check("mix_only_on_commit", 32'(fd), 32'd1);
    prev_mix = mix;
    prev_ok  = rst;
  end

  // Reference: sum of answering enabled voices, clamp, round length.
  task automatic model(input logic [3:0] e, output int len, output logic [15:0] m,
                       output bit clipped, output bit tmo);
    int sum;
    sum = 0;
    len = 2;
    tmo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (e[i]) begin
        if (lat[i] >= 1 && lat[i] <= TMO) begin
          sum += int'($signed(samp[i]));
          len += 1 + lat[i];
        end else begin
          tmo = 1'b1;
          len += 1 + TMO;
        end
      end else begin
        len += 1;
      end
    end
    clipped = (sum > 32767) || (sum < -32768);
    m = (sum > 32767) ? 16'h7fff : (sum < -32768) ? 16'h8000 : 16'(sum);
  endtask

  task automatic run_round(input string tag, input logic [3:0] e);
    int len, cnt;
    logic [15:0] em;
    bit ec, et, done;
    model(e, len, em, ec, et);
    en = e;
    seen = '0;
    @(negedge clk);
    ws = 1'b0;
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < len + 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 4) ws = 1'b1;
      if (fd) done = 1'b1;
    end
    m_clip |= ec;
    m_to   |= et;
    check({tag, "_len"},     32'(cnt),    32'(len + 3));
    check({tag, "_mix"},     32'(mix),    32'(em));
    check({tag, "_clip"},    32'(clip),   32'(m_clip));
    check({tag, "_timeout"}, 32'(tmo_f),  32'(m_to));
    check({tag, "_overrun"}, 32'(ovr),    32'(m_ov));
    check({tag, "_polled"},  32'(seen),   32'(e));
    @(negedge clk);
    check({tag, "_fd_pulse"}, 32'(fd), 32'd0);
  endtask

  task automatic clear_all();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_clip = 1'b0;
    m_to   = 1'b0;
    m_ov   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mix"},  32'(mix),   32'd0);
    check({tag, "_req"},  32'(req),   32'd0);
    check({tag, "_sel"},  32'(sel),   32'd0);
    check({tag, "_fd"},   32'(fd),    32'd0);
    check({tag, "_clip"}, 32'(clip),  32'd0);
    check({tag, "_to"},   32'(tmo_f), 32'd0);
    check({tag, "_ovr"},  32'(ovr),   32'd0);
  endtask

  initial begin
    int cnt, pulses, fd_at;
    bit found;
    rst = 1'b0;
    ws = 1'b1;
    clear = 1'b0;
    en = '0;
    m_clip = 0; m_to = 0; m_ov = 0;
    for (int i = 0; i < 4; i++) begin lat[i] = 1; samp[i] = '0; end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Basic sum, every voice answers in its first WAIT cycle.
    samp[0] = 16'd100; samp[1] = -16'sd50; samp[2] = 16'd1000; samp[3] = 16'd7;
    run_round("basic", 4'hF);

    // Positive and negative saturation, then clear the sticky clip.
    samp[0] = 16'h7fff; samp[1] = 16'h7fff; samp[2] = 16'h0001; samp[3] = 16'h0000;
    run_round("sat_pos", 4'hF);
    for (int i = 0; i < 4; i++) samp[i] = 16'h8000;
    run_round("sat_neg", 4'hF);
    clear_all();
    check("clear_clip", 32'(clip), 32'd0);

    // Mask with voice 2 silent.
    lat[0] = 1; samp[0] = -16'sd3; lat[2] = 0;
    run_round("mask", 4'b0101);
    clear_all();

    // Answer on the last allowed WAIT cycle counts; one later times out.
    lat[0] = TMO; samp[0] = 16'd5;
    run_round("lat_edge", 4'b0001);
    lat[0] = TMO + 1;
    run_round("lat_over", 4'b0001);
    clear_all();
    check("clear_timeout", 32'(tmo_f), 32'd0);

    // No voices enabled commits zero.
    run_round("none", 4'b0000);

    // Randomized rounds.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) begin
        lat[i]  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
        samp[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000);
      end
      if ($urandom_range(0, 3) == 0) clear_all();
      run_round("rand", 4'($urandom));
    end

    // Overrun: second frame start lands while every voice is timing out.
    clear_all();
    for (int i = 0; i < 4; i++) lat[i] = 0;
    en = 4'hF;
    @(negedge clk);
    ws = 1'b0;
    cnt = 0; pulses = 0; fd_at = 0;
    while (cnt < 700) begin
      @(negedge clk);
      cnt++;
      if (cnt == 4 || cnt == 66) ws = 1'b1;
      if (cnt == 60) ws = 1'b0;
      if (fd) begin pulses++; fd_at = cnt; end
    end
    check("ovr_flag",    32'(ovr),    32'd1);
    check("ovr_pulses",  32'(pulses), 32'd1);
    check("ovr_fd_time", 32'(fd_at),  32'(4 * (1 + TMO) + 2 + 3));
    check("ovr_mix",     32'(mix),    32'd0);
    check("ovr_timeout", 32'(tmo_f),  32'd1);
    clear_all();
    check("clear_overrun", 32'(ovr), 32'd0);

    // Reset while voice 2 is being requested.
    lat[0] = 1; lat[1] = 2; lat[2] = 0; lat[3] = 1;
    samp[0] = 16'd11; samp[1] = 16'd22; samp[2] = 16'd33; samp[3] = 16'd44;
    run_round("pre_reset", 4'hF);
    en = 4'hF;
    @(negedge clk);
    ws = 1'b0;
    cnt = 0; found = 1'b0;
    while (!found && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 4) ws = 1'b1;
      if (req && sel == 2'd2) found = 1'b1;
    end
    check("reach_v2_wait", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_clip = 0; m_to = 0; m_ov = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("no_false_start", 32'(req), 32'd0);
    lat[2] = 3;
    run_round("post_reset", 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
